uart_rx: RTL and testbench

- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter.
- Frame format: 8N1, idle-high line, one low start bit, 8 data bits LSB first, one high stop bit.
- Runs entirely in the system clock domain and uses an internal baud counter, not a derived clock.
- Delivers each received byte with a one-cycle done strobe and flags framing errors.

---
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling from an internal
// baud counter, one-cycle done / framing-error strobes.
module uart_rx #(
   parameter int clk_freq  = 1000000,
   parameter int baud_rate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       donerx,
   output logic       frame_err,
   output logic       busy
);

   localparam int BIT   = clk_freq / baud_rate;
   localparam int HALF  = BIT / 2;
   localparam int CNT_W = $clog2(BIT + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             donerx_q, donerx_d;
   logic             frame_err_q, frame_err_d;
   logic             rx_s;

   assign rx_s = sync2_q;

   always_comb begin
      sync1_d     = rx;
      sync2_d     = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      donerx_d    = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = 3'd0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            // A start bit that is no longer low at mid-bit is a glitch, not a frame.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  rx_data_d = shift_q;
                  donerx_d  = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         donerx_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         donerx_q    <= donerx_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign donerx    = donerx_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized at chosen bit periods, the
// expected outcome of each frame is queued, and a monitor checks every output pulse.
module tb_uart_rx;

   localparam int BIT = 104;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] rx_data;
   logic       donerx;
   logic       frame_err;
   logic       busy;

   uart_rx #(.clk_freq(1000000), .baud_rate(9600)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
      .donerx(donerx), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t       sbq[$];
   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] model_last = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // A good frame updates the byte the receiver should be holding; a bad one must not.
   task automatic exp_good(input logic [7:0] b);
      sbq.push_back({1'b0, b});
      model_last = b;
   endtask

   task automatic exp_err();
      sbq.push_back({1'b1, model_last});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v,
                             input int stop_len);
      rx = 1'b0;
      tick(per);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(per);
      end
      rx = stop_v;
      tick(stop_len);
      rx = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (donerx || frame_err) begin
         if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_pulse: got donerx=%0b frame_err=%0b expected none at %0t",
                     donerx, frame_err, $time);
         end else begin
            e = sbq.pop_front();
            chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
            chk("pulse_exclusive", {31'd0, donerx & frame_err}, 32'd0);
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
         end
      end
   end

   initial begin
      logic [7:0] b;
      int         per;
      int         gap;
      rx  = 1'b1;
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("rst_donerx", {31'd0, donerx}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick(10);

      exp_good(8'h55);
      fork
         send_frame(8'h55, BIT, 1'b1, BIT);
         begin
            tick(5 * BIT);
            @(negedge clk);
            chk("busy_mid_frame", {31'd0, busy}, 32'd1);
         end
      join
      @(negedge clk);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      tick(20);

      exp_good(8'hA5);
      send_frame(8'hA5, BIT, 1'b1, BIT);
      exp_good(8'h3C);
      send_frame(8'h3C, BIT, 1'b1, BIT);
      tick(BIT);

      // Short low pulse: busy must rise, then fall without any strobe.
      rx = 1'b0;
      tick(10);
      @(negedge clk);
      chk("glitch_busy", {31'd0, busy}, 32'd1);
      tick(10);
      rx = 1'b1;
      tick(2 * BIT);
      @(negedge clk);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      chk("glitch_rx_data", {24'd0, rx_data}, {24'd0, model_last});

      exp_err();
      send_frame(8'hF0, BIT, 1'b0, 3 * BIT);
      tick(2 * BIT);
      exp_good(8'h81);
      send_frame(8'h81, BIT, 1'b1, BIT);
      tick(BIT);

      fork
         send_frame(8'hFF, BIT, 1'b1, BIT);
         begin
            tick(5 * BIT + BIT / 2);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            @(negedge clk);
            chk("midrst_busy", {31'd0, busy}, 32'd0);
            chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
         end
      join
      model_last = 8'h00;
      tick(BIT);
      exp_good(8'h12);
      send_frame(8'h12, BIT, 1'b1, BIT);
      tick(BIT);

      // Slow transmitter at 106-cycle bits, frames back to back.
      exp_good(8'h00);
      send_frame(8'h00, 106, 1'b1, 106);
      exp_good(8'hFF);
      send_frame(8'hFF, 106, 1'b1, 106);
      exp_good(8'h6B);
      send_frame(8'h6B, 106, 1'b1, 106);
      tick(BIT);

      for (int k = 0; k < 16; k++) begin
         b   = 8'($urandom);
         per = $urandom_range(100, 108);
         gap = $urandom_range(0, 50);
         if ($urandom_range(0, 5) == 0) begin
            exp_err();
            send_frame(b, per, 1'b0, 3 * per);
            tick(per + gap);
         end else begin
            exp_good(b);
            send_frame(b, per, 1'b1, per);
            tick(gap);
         end
      end

      tick(3 * BIT);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
